// File: rtl/enigma_pkg.sv
//------------------------------------------------------------------------------
// enigma_pkg : shared tables and mod-26 helpers for the three-rotor Enigma core
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package enigma_pkg;

  localparam int ALPHA      = 26;
  localparam int NUM_ROTORS = 5;

  typedef logic [ALPHA*8-1:0] wstr_t;  // wiring as an ASCII string, first letter in the MSBs
  typedef logic [ALPHA*5-1:0] tbl_t;   // 26 packed 5-bit entries, entry k at [5k +: 5]

  localparam wstr_t ROTOR_WIRING [NUM_ROTORS] = '{
    "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
    "AJDKSIRUXBLHWTMCQGZNPYFVOE",
    "BDFHJLCPRTXVZNYEIWGAKMUSQO",
    "ESOVPZJAYQUIRHXLNFTGKDCMWB",
    "VZBRGITYUPSDNHLXAWMJQOFECK"
  };

  localparam wstr_t REFLECTOR_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  localparam logic [4:0] NOTCH [NUM_ROTORS] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25};

  function automatic logic [4:0] char_idx(wstr_t s, logic [4:0] k);
    logic [7:0] ch;
    ch = s[8*(ALPHA-1-int'(k)) +: 8];
    return 5'(ch - 8'd65);
  endfunction

  // Forward or inverse wiring of one rotor type, evaluated at elaboration time.
  function automatic tbl_t build_table(int unsigned rot, bit inv);
    tbl_t       t;
    logic [4:0] w;
    t = '0;
    for (int k = 0; k < ALPHA; k++) begin
      w = char_idx(ROTOR_WIRING[rot], 5'(k));
      if (inv) t[5*int'(w) +: 5] = 5'(k);
      else     t[5*k +: 5]       = w;
    end
    return t;
  endfunction

  function automatic logic [4:0] tbl_get(tbl_t t, logic [4:0] k);
    return t[5*int'(k) +: 5];
  endfunction

  function automatic logic [4:0] add26(logic [4:0] a, logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] sub26(logic [4:0] a, logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] inc26(logic [4:0] a);
    return add26(a, 5'd1);
  endfunction

  function automatic logic [4:0] reflect_b(logic [4:0] k);
    return char_idx(REFLECTOR_B, k);
  endfunction

endpackage

`default_nettype wire

// File: rtl/enigma_rotor_map.sv
//------------------------------------------------------------------------------
// enigma_rotor_map : combinational pass through one rotor slot (fwd or inverse)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module enigma_rotor_map
  import enigma_pkg::*;
#(
  parameter int unsigned ROT = 0,
  parameter bit          INV = 1'b0
) (
  input  logic [4:0] i_idx,
  input  logic [4:0] i_pos,
  output logic [4:0] o_idx
);

  localparam tbl_t c_tbl = build_table(ROT, INV);

  logic [4:0] w_entry;

  assign w_entry = tbl_get(c_tbl, add26(i_idx, i_pos));
  assign o_idx   = sub26(w_entry, i_pos);

endmodule

`default_nettype wire

// File: rtl/enigma_core.sv
//------------------------------------------------------------------------------
// enigma_core : three-rotor Enigma engine, reflector B, two-stage pipeline
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module enigma_core
  import enigma_pkg::*;
#(
  parameter int unsigned ROT_L = 0,
  parameter int unsigned ROT_M = 1,
  parameter int unsigned ROT_R = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic signed [5:0] sym_i,
  input  logic              cfg_load_i,
  input  logic [14:0]       cfg_pos_i,
  output logic signed [5:0] sym_o,
  output logic              sym_vld_o,
  output logic [14:0]       rot_pos_o
);

  localparam logic [4:0] c_notch_m = NOTCH[ROT_M];
  localparam logic [4:0] c_notch_r = NOTCH[ROT_R];

  logic [4:0] r_pos_l, r_pos_m, r_pos_r;
  logic       r_s1_vld;
  logic [4:0] r_s1_idx;
  logic       r_out_vld;
  logic [5:0] r_out_sym;

  logic       w_accept;
  logic       w_m_notch, w_r_notch;
  logic [4:0] w_nxt_l, w_nxt_m, w_nxt_r;
  logic [4:0] w_in_idx, w_f_r, w_f_m, w_f_l, w_refl;
  logic [4:0] w_i_l, w_i_m, w_i_r;

  function automatic logic [4:0] clip_pos(logic [4:0] f);
    return (f >= 5'd26) ? 5'd0 : f;
  endfunction

  assign w_accept = !cfg_load_i && (sym_i > 6'sd0) && (sym_i <= 6'sd26);
  assign w_in_idx = sym_i[4:0] - 5'd1;

  // Middle-rotor notch also steps the middle rotor itself: the historical double-step.
  assign w_m_notch = (r_pos_m == c_notch_m);
  assign w_r_notch = (r_pos_r == c_notch_r);
  assign w_nxt_r   = inc26(r_pos_r);
  assign w_nxt_m   = (w_r_notch || w_m_notch) ? inc26(r_pos_m) : r_pos_m;
  assign w_nxt_l   = w_m_notch ? inc26(r_pos_l) : r_pos_l;

  enigma_rotor_map #(.ROT(ROT_R), .INV(1'b0)) u_fwd_r (.i_idx(w_in_idx), .i_pos(w_nxt_r), .o_idx(w_f_r));
  enigma_rotor_map #(.ROT(ROT_M), .INV(1'b0)) u_fwd_m (.i_idx(w_f_r),    .i_pos(w_nxt_m), .o_idx(w_f_m));
  enigma_rotor_map #(.ROT(ROT_L), .INV(1'b0)) u_fwd_l (.i_idx(w_f_m),    .i_pos(w_nxt_l), .o_idx(w_f_l));

  assign w_refl = reflect_b(w_f_l);

  // Stage 2 runs against the position registers, which already hold this letter's stepped values.
  enigma_rotor_map #(.ROT(ROT_L), .INV(1'b1)) u_inv_l (.i_idx(r_s1_idx), .i_pos(r_pos_l), .o_idx(w_i_l));
  enigma_rotor_map #(.ROT(ROT_M), .INV(1'b1)) u_inv_m (.i_idx(w_i_l),    .i_pos(r_pos_m), .o_idx(w_i_m));
  enigma_rotor_map #(.ROT(ROT_R), .INV(1'b1)) u_inv_r (.i_idx(w_i_m),    .i_pos(r_pos_r), .o_idx(w_i_r));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pos_l   <= 5'd0;
      r_pos_m   <= 5'd0;
      r_pos_r   <= 5'd0;
      r_s1_vld  <= 1'b0;
      r_s1_idx  <= 5'd0;
      r_out_vld <= 1'b0;
      r_out_sym <= 6'd0;
    end else begin
      r_out_vld <= r_s1_vld;
      r_out_sym <= r_s1_vld ? ({1'b0, w_i_r} + 6'd1) : 6'd0;
      r_s1_vld  <= w_accept;
      r_s1_idx  <= w_refl;
      if (cfg_load_i) begin
        r_pos_l <= clip_pos(cfg_pos_i[14:10]);
        r_pos_m <= clip_pos(cfg_pos_i[9:5]);
        r_pos_r <= clip_pos(cfg_pos_i[4:0]);
      end else if (w_accept) begin
        r_pos_l <= w_nxt_l;
        r_pos_m <= w_nxt_m;
        r_pos_r <= w_nxt_r;
      end
    end
  end

  assign sym_o     = $signed(r_out_sym);
  assign sym_vld_o = r_out_vld;
  assign rot_pos_o = {r_pos_l, r_pos_m, r_pos_r};

endmodule

`default_nettype wire

// File: tb/tb_enigma_core.sv
//------------------------------------------------------------------------------
// tb_enigma_core : directed and random checks of enigma_core against a string model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_enigma_core;

  logic              clk_i;
  logic              rst_i;
  logic signed [5:0] sym_i;
  logic              cfg_load_i;
  logic [14:0]       cfg_pos_i;
  logic signed [5:0] sym_o;
  logic              sym_vld_o;
  logic [14:0]       rot_pos_o;

  enigma_core #(.ROT_L(0), .ROT_M(1), .ROT_R(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sym_i      (sym_i),
    .cfg_load_i (cfg_load_i),
    .cfg_pos_i  (cfg_pos_i),
    .sym_o      (sym_o),
    .sym_vld_o  (sym_vld_o),
    .rot_pos_o  (rot_pos_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  string c_rot [5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                       "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                       "VZBRGITYUPSDNHLXAWMJQOFECK"};
  string c_refl = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  int    c_notch [5] = '{16, 4, 21, 9, 25};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: window positions and what each pipeline stage holds.
  int m_l, m_m, m_r;
  bit m_s1_vld;
  int m_s1;
  bit m_out_vld;
  int m_out;
  int got[$];

  function automatic int rotor_fwd(int rot, int x, int p);
    return ((c_rot[rot][(x + p) % 26] - 65) - p + 26) % 26;
  endfunction

  function automatic int rotor_inv(int rot, int x, int p);
    int tgt = (x + p) % 26;
    for (int k = 0; k < 26; k++)
      if (c_rot[rot][k] - 65 == tgt) return (k - p + 26) % 26;
    return -1;
  endfunction

  function automatic int encipher(int c, int pl, int pm, int pr);
    int x;
    x = rotor_fwd(2, c, pr);
    x = rotor_fwd(1, x, pm);
    x = rotor_fwd(0, x, pl);
    x = c_refl[x] - 65;
    x = rotor_inv(0, x, pl);
    x = rotor_inv(1, x, pm);
    x = rotor_inv(2, x, pr);
    return x;
  endfunction

  function automatic int model_pos();
    return (m_l << 10) | (m_m << 5) | m_r;
  endfunction

  task automatic model_reset();
    m_l = 0; m_m = 0; m_r = 0;
    m_s1_vld = 0; m_s1 = 0; m_out_vld = 0; m_out = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare outputs.
  task automatic cycle(input int s, input bit ld, input int lpos);
    bit m_mid, m_rn;
    sym_i      = 6'(s);
    cfg_load_i = ld;
    cfg_pos_i  = 15'(lpos);
    @(posedge clk_i);
    m_out_vld = m_s1_vld;
    m_out     = m_s1_vld ? m_s1 : 0;
    m_s1_vld  = 0;
    if (rst_i) begin
      if (ld) begin
        m_l = ((lpos >> 10) & 31) >= 26 ? 0 : (lpos >> 10) & 31;
        m_m = ((lpos >> 5) & 31)  >= 26 ? 0 : (lpos >> 5) & 31;
        m_r = (lpos & 31)         >= 26 ? 0 : lpos & 31;
      end else if (s >= 1 && s <= 26) begin
        m_mid = (m_m == c_notch[1]);
        m_rn  = (m_r == c_notch[2]);
        m_r   = (m_r + 1) % 26;
        if (m_rn || m_mid) m_m = (m_m + 1) % 26;
        if (m_mid)         m_l = (m_l + 1) % 26;
        m_s1     = encipher(s - 1, m_l, m_m, m_r) + 1;
        m_s1_vld = 1;
      end
    end else begin
      model_reset();
    end
    #1;
    check("rot_pos", 32'(rot_pos_o), 32'(model_pos()));
    check("sym_vld", 32'(sym_vld_o), 32'(m_out_vld));
    check("sym_o",   32'(unsigned'(sym_o)), 32'(m_out));
    if (sym_vld_o === 1'b1) got.push_back(int'(unsigned'(sym_o)));
  endtask

  int kat_bdzgo [5] = '{2, 4, 26, 7, 15};
  int s_rand, p_rand;
  bit l_rand;

  initial begin
    rst_i = 1'b0; sym_i = '0; cfg_load_i = 1'b0; cfg_pos_i = '0;
    model_reset();
    #12;
    check("reset_pos", 32'(rot_pos_o), 32'd0);
    check("reset_vld", 32'(sym_vld_o), 32'd0);
    check("reset_sym", 32'(unsigned'(sym_o)), 32'd0);
    rst_i = 1'b1;

    // AAAAA from AAA enciphers to BDZGO.
    got.delete();
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("kat_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("kat_bdzgo", 32'(got[i]), 32'(kat_bdzgo[i]));
    check("kat_pos", 32'(rot_pos_o), 32'd5);

    // Double-step: ADU -> ADV -> AEW -> BFX.
    cycle(0, 1, (0 << 10) | (3 << 5) | 20);
    for (int i = 0; i < 3; i++) cycle($urandom_range(1, 26), 0, 0);
    check("dstep_pos", 32'(rot_pos_o), 32'((1 << 10) | (5 << 5) | 23));
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    // Reciprocity: BDZGO from AAA returns AAAAA.
    cycle(0, 1, 0);
    got.delete();
    for (int i = 0; i < 5; i++) cycle(kat_bdzgo[i], 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("recip_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size(); i++) check("recip_a", 32'(got[i]), 32'd1);

    // Load beats a simultaneous letter; out-of-range fields load as 0.
    got.delete();
    cycle(5, 1, (30 << 10) | (3 << 5) | 30);
    check("load_clip", 32'(rot_pos_o), 32'(3 << 5));
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("load_drop", 32'(got.size()), 32'd0);

    // Idle codes never step or emit.
    foreach (kat_bdzgo[i]) cycle(0, 0, 0);
    cycle(27, 0, 0); cycle(31, 0, 0); cycle(32, 0, 0); cycle(63, 0, 0); cycle(40, 0, 0);
    check("idle_pos", 32'(rot_pos_o), 32'(3 << 5));

    // Asynchronous reset with a letter in flight.
    got.delete();
    cycle(3, 0, 0);
    #2 rst_i = 1'b0;
    #1;
    check("areset_pos", 32'(rot_pos_o), 32'd0);
    check("areset_vld", 32'(sym_vld_o), 32'd0);
    model_reset();
    cycle(0, 0, 0);
    rst_i = 1'b1;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("areset_drop", 32'(got.size()), 32'd0);

    // Random traffic with occasional reloads.
    for (int i = 0; i < 600; i++) begin
      l_rand = ($urandom_range(0, 15) == 0);
      p_rand = $urandom_range(0, 32767);
      s_rand = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 26) : $urandom_range(0, 63);
      cycle(s_rand, l_rand, p_rand);
    end
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
